// File: rtl/fifo_arb_pkg.sv
// Shared types and widths for the FIFO push arbiter.
// Holds the FSM state encoding and the round-robin index helper.
package fifo_arb_pkg;

  localparam int unsigned GRANT_W = 3;
  localparam int unsigned BEAT_W  = 4;
  localparam int unsigned SUM_W   = GRANT_W + 1;
  localparam int unsigned PAD_W   = 1 << GRANT_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // (base + step) mod n, kept in SUM_W bits so the wrap never overflows
  function automatic logic [GRANT_W-1:0] rr_index(
    input logic [GRANT_W-1:0] base,
    input logic [SUM_W-1:0]   step,
    input logic [SUM_W-1:0]   n
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + step;
    if (sum >= n) begin
      sum = sum - n;
    end
    return sum[GRANT_W-1:0];
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin picker: first requester set at or after last_grant+1 (mod N_REQ).
// Purely combinational.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic               any_req,
  output logic [GRANT_W-1:0] next_idx
);

  logic [PAD_W-1:0] req_pad;

  assign req_pad = PAD_W'(req);

  // Scan farthest-first so the nearest candidate after last_grant wins
  always_comb begin
    any_req  = |req;
    next_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_pad[rr_index(last_grant, SUM_W'(k), SUM_W'(N_REQ))]) begin
        next_idx = rr_index(last_grant, SUM_W'(k), SUM_W'(N_REQ));
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one FIFO write port among N_REQ producers with round-robin,
// burst-bounded grants; push/ack/data follow the registered grant combinationally.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  input  logic                    fifo_full,
  output logic                    fifo_push,
  output logic [DATA_W-1:0]       fifo_data,
  output logic                    busy,
  output logic [GRANT_W-1:0]      grant_id
);

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic [GRANT_W-1:0] grant_nxt;
  logic [GRANT_W-1:0] last_grant;
  logic [GRANT_W-1:0] last_nxt;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0]  beat_nxt;
  logic               any_req;
  logic [GRANT_W-1:0] pick_idx;
  logic               sel_req;
  logic [DATA_W-1:0]  sel_data;

  fifo_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req       (req),
    .last_grant(last_grant),
    .any_req   (any_req),
    .next_idx  (pick_idx)
  );

  // Select the granted requester's request and byte
  always_comb begin
    sel_req  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == GRANT_W'(i)) begin
        sel_req  = req[i];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_id   <= '0;
      beat_cnt   <= '0;
      last_grant <= GRANT_W'(N_REQ - 1);
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      beat_cnt   <= beat_nxt;
      last_grant <= last_nxt;
    end
  end

  // Next state plus push/ack/data; a stall (full with req held) keeps everything
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    beat_nxt  = beat_cnt;
    last_nxt  = last_grant;
    fifo_push = 1'b0;
    fifo_data = '0;
    ack       = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt = pick_idx;
          beat_nxt  = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        fifo_data = sel_data;
        if (!sel_req) begin
          last_nxt  = grant_id;
          state_nxt = IDLE;
        end else if (!fifo_full) begin
          fifo_push = 1'b1;
          beat_nxt  = beat_cnt + BEAT_W'(1);
          for (int i = 0; i < N_REQ; i++) begin
            ack[i] = (grant_id == GRANT_W'(i));
          end
          if (beat_nxt == BEAT_W'(MAX_BURST)) begin
            last_nxt  = grant_id;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter: a transaction-level model predicts
// each push; a monitor compares DUT pushes, acks, busy and grant_id.
module tb_fifo_push_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  ack;
  logic          fifo_full;
  logic          fifo_push;
  logic [DW-1:0] fifo_data;
  logic          busy;
  logic [2:0]    grant_id;

  always #5 clk = ~clk;

  fifo_push_arbiter #(
    .N_REQ    (N),
    .DATA_W   (DW),
    .MAX_BURST(MB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .fifo_full(fifo_full),
    .fifo_push(fifo_push),
    .fifo_data(fifo_data),
    .busy     (busy),
    .grant_id (grant_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Per-requester byte queues (head/tail into fixed storage)
  logic [DW-1:0] mem [N][DEPTH];
  int head [N];
  int tail [N];
  int push_count [N];

  logic [15:0] sb [$];

  // Model: owner = -1 while arbitrating, else the requester holding the grant
  int m_owner, m_cnt, m_last, m_gid;
  int nx_owner, nx_cnt, nx_last, nx_gid, pop_id;
  bit exp_push, exp_busy;
  int exp_gid;
  bit full_now;
  bit pending_release;
  bit mon_en;
  int run_id, run_len;
  logic [15:0] mon_e;
  logic [N-1:0] mon_ack;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic load_byte(input int r, input logic [DW-1:0] b);
    mem[r][tail[r]] = b;
    tail[r]++;
  endtask

  task automatic load(input int r, input int n);
    for (int j = 0; j < n; j++) load_byte(r, DW'($urandom));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = (head[i] != tail[i]);
      req_data[i*DW +: DW] = req[i] ? mem[i][head[i]] : DW'($urandom);
    end
    fifo_full = full_now;
  endtask

  task automatic predict();
    bit found;
    int idx;
    exp_busy = (m_owner >= 0);
    exp_gid  = m_gid;
    exp_push = 1'b0;
    nx_owner = m_owner;
    nx_cnt   = m_cnt;
    nx_last  = m_last;
    nx_gid   = m_gid;
    pop_id   = -1;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && head[idx] != tail[idx]) begin
          found    = 1'b1;
          nx_owner = idx;
          nx_gid   = idx;
          nx_cnt   = 0;
        end
      end
    end else if (head[m_owner] == tail[m_owner]) begin
      nx_last  = m_owner;
      nx_owner = -1;
    end else if (!full_now) begin
      exp_push = 1'b1;
      sb.push_back({8'(m_owner), mem[m_owner][head[m_owner]]});
      pop_id = m_owner;
      nx_cnt = m_cnt + 1;
      if (nx_cnt == MB) begin
        nx_last  = m_owner;
        nx_owner = -1;
      end
    end
  endtask

  task automatic commit();
    m_owner = nx_owner;
    m_cnt   = nx_cnt;
    m_last  = nx_last;
    m_gid   = nx_gid;
    if (pop_id >= 0) begin
      head[pop_id]++;
      push_count[pop_id]++;
    end
  endtask

  task automatic cycle(input bit full_in, input bit mid_reset);
    @(negedge clk);
    if (pending_release) begin
      reset = 1'b0;
      pending_release = 1'b0;
    end
    full_now = full_in;
    drive();
    #1 predict();
    if (mid_reset) begin
      #2 reset = 1'b1;
      #1;
      chk("rst_async_push", fifo_push, 0);
      chk("rst_async_ack", ack, 0);
      chk("rst_async_busy", busy, 0);
      chk("rst_async_gid", grant_id, 0);
      m_owner = -1;
      m_cnt   = 0;
      m_last  = N - 1;
      m_gid   = 0;
      sb.delete();
      pending_release = 1'b1;
      @(posedge clk);
    end else begin
      @(posedge clk);
      commit();
    end
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) e = 1'b0;
    return e;
  endfunction

  task automatic drain();
    int guard;
    guard = 0;
    while (!all_empty() && guard < 600) begin
      cycle(1'b0, 1'b0);
      guard++;
    end
    if (guard >= 600) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: queues still pending after %0d cycles", guard);
    end
    repeat (3) cycle(1'b0, 1'b0);
  endtask

  // Monitor: compare every cycle against the model's prediction
  always @(negedge clk) begin
    #2;
    if (mon_en && !reset) begin
      chk("busy", busy, exp_busy);
      chk("grant_id", grant_id, exp_gid);
      chk("push", fifo_push, exp_push);
      if (fifo_push) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_push: got data %0h with empty scoreboard", fifo_data);
        end else begin
          mon_e = sb.pop_front();
          mon_ack = '0;
          mon_ack[int'(mon_e[15:8])] = 1'b1;
          chk("push_data", fifo_data, mon_e[7:0]);
          chk("push_ack", ack, mon_ack);
          if (int'(grant_id) == run_id) run_len++;
          else begin
            run_id  = int'(grant_id);
            run_len = 1;
          end
          chk("burst_bound", run_len <= MB, 1);
        end
      end else begin
        chk("ack_idle", ack, 0);
        run_len = 0;
      end
    end
  end

  initial begin
    int base, guard;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
      push_count[i] = 0;
    end
    m_owner = -1; m_cnt = 0; m_last = N - 1; m_gid = 0;
    run_id = -1; run_len = 0;
    mon_en = 1'b0; full_now = 1'b0; pending_release = 1'b0;
    req = '0; req_data = '0; fifo_full = 1'b0;
    reset = 1'b1;
    #1;
    chk("reset_push", fifo_push, 0);
    chk("reset_ack", ack, 0);
    chk("reset_busy", busy, 0);
    chk("reset_gid", grant_id, 0);
    chk("reset_data", fifo_data, 0);
    repeat (2) @(posedge clk);
    pending_release = 1'b1;
    mon_en = 1'b1;

    // Single requester, three bytes then drop
    load_byte(0, 8'h11); load_byte(0, 8'h22); load_byte(0, 8'h33);
    repeat (8) cycle(1'b0, 1'b0);

    // Round-robin over three requesters, two bytes each
    load(0, 2); load(1, 2); load(2, 2);
    repeat (14) cycle(1'b0, 1'b0);

    // Burst limit with two continuous requesters
    load(1, 12); load(3, 12);
    drain();

    // Backpressure: full for three cycles after two pushes
    load(0, 4);
    repeat (3) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b0);
    drain();

    // Reset after the second push of requester 2
    load(2, 4);
    base = push_count[2];
    guard = 0;
    while (push_count[2] < base + 2 && guard < 30) begin
      cycle(1'b0, 1'b0);
      guard++;
    end
    if (guard >= 30) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_r2_push: got %0d pushes expected %0d", push_count[2] - base, 2);
    end
    cycle(1'b0, 1'b1);
    load(0, 2);
    drain();

    // Requester drops after one byte; next in rotation follows
    load(1, 1); load(2, 3);
    repeat (12) cycle(1'b0, 1'b0);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 4) == 0) load(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 4)));
      cycle($urandom_range(0, 4) == 0, 1'b0);
    end
    drain();

    chk("scoreboard_empty", sb.size(), 0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
